seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the stopwatch counter chain and takes the four BCD digits (digit0 least significant, digit3 most significant). It drives one digit at a time onto shared active-low cathodes, scanning the active-low anodes at a fixed refresh rate. Digits are captured once per scan frame so no frame mixes old and new values. It also provides:
- decimal-point control,
- per-digit blanking,
- leading-zero suppression,
- a freeze (lap-hold) input,
- an anti-ghosting guard interval.

## Interface
- REFRESH_COUNT, 100000: clocks per digit slot (1 ms at 100 MHz); must be > GUARD.
- REFRESH_WIDTH, 17: width of refresh counter; must hold REFRESH_COUNT-1.
- GUARD, 4: clocks at the start of each slot with all anodes off.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; the block is reset on any rising clk edge where reset==0.
- digit0..digit3  in  4 each  digit values; 0–9 are normal BCD, 10–15 display as hex A–F.
- dp_en  in  4  bit i lights the decimal point on digit i.
- blank  in  4  bit i forces digit i dark (anode off).
- lzb  in  1  leading-zero blanking enable.
- freeze  in  1  while 1, the captured digits/dp_en/blank are held.
- anode  out  4  active-low digit enables; bit i = digit i.
- segment  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.

## Operation
- **Refresh counter.** The counter rc counts 0..REFRESH_COUNT-1 and wraps to 0. tick = (rc == REFRESH_COUNT-1).
- **Scan index.** The 2-bit index idx advances on tick: 0→1→2→3→0.
- **Frame capture.**
  - frame_start = (tick && idx==3) || init.
  - init is a flag set by reset and cleared on the first cycle after reset deasserts.
  - On frame_start with freeze==0, shadow registers capture digit0..3, dp_en and blank.
  - With freeze==1 the shadows hold; counter and scan continue unaffected.
- **Leading-zero blanking** (combinational from shadows, lzb==1 only):
  - z3 = (s3==0).
  - z2 = z3 && (s2==0).
  - z1 = z2 && (s1==0).
  - digit0 is never suppressed.
  - Suppressed digits are dark; their dp is still driven if the dp_en bit is set, with segment all off.
- **Digit dark condition.** Digit idx is dark if blank[idx] is set, or it is suppressed with dp_en[idx]==0, or rc < GUARD.
- **Outputs** (all registered):
  - anode = ~(1<<idx), or 4'b1111 when dark.
  - segment = decode(s[idx]), or 7'b1111111 when dark or suppressed.
  - dp = ~dp_en[idx], forced to 1 when the digit is dark.
- **Decode**, {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
- **Reset values:**
  - rc=0, idx=0, shadows=0, init=1.
  - anode=4'b1111, segment=7'b1111111, dp=1.
- Reset asserted mid-slot or mid-frame takes priority over everything and restores all reset values on that edge.

## Timing
- **Output latency.** Outputs are registered, so they reflect rc/idx/shadow state of the previous cycle: 1-cycle latency.
- **Slot length.** Each slot is exactly REFRESH_COUNT cycles; a full frame is 4*REFRESH_COUNT cycles.
- **Guard timing.** The anode for a new idx goes low on the cycle (GUARD+1) cycles after the tick that selected it. Segment and dp change together with the anode; they are never out of step.
- **Capture timing.** Input changes become visible at the next frame_start only, with at most 4*REFRESH_COUNT+1 cycles of delay. Changes between frame_starts are ignored.
- **First frame.** The first capture happens on the first cycle after reset release (init), so the first frame shows live inputs.
- **Freeze timing.** freeze is sampled only at frame_start. Toggling it mid-frame has no effect until the next frame boundary.

## Test plan
All scenarios use REFRESH_COUNT=8, GUARD=2.
- **Reset/first frame.** Hold reset=0 for 3 clocks with digits=1,2,3,4 and lzb=0 → during reset anode=1111 and segment=1111111. After release, anode=1110 with segment=1111001 (digit0=1) appears in cycles 3–8 of slot 0. Then slot 1 shows digit1=2 as 0100100, and so on.
- **Scan order/wrap.** Run 40 cycles → anode sequence 1110,1101,1011,0111,1110. Each is low for exactly 6 of every 8 cycles, with 1111 in the 2 guard cycles.
- **Frame coherence.** Change digits from 1,2,3,4 to 5,6,7,8 while idx==1 → slots 1–3 of the current frame still show 2,3,4. The next frame shows 5,6,7,8.
- **Leading-zero blanking.** digits d3..d0=0,0,0,7, lzb=1, dp_en=4'b0100 → anodes 0111 are never low. Anode 1011 goes low with segment=1111111 and dp=0. Anode 1110 shows 1111000 (digit 7). Digit0 with value 0 is still displayed.
- **Freeze.** Assert freeze=1 before a frame boundary, then change digits → display holds the old values indefinitely. Deassert freeze → new values appear at the next frame_start.
- **Reset mid-slot.** Pull reset=0 at rc=5 of slot 2 → on the next edge all outputs return to reset values. After release, scanning restarts at idx=0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver with frame-coherent digit capture,
// leading-zero blanking, lap-hold freeze and an anti-ghosting guard at each slot start.
module seven_seg_scanner #(
  parameter int REFRESH_COUNT = 100000,
  parameter int REFRESH_WIDTH = 17,
  parameter int GUARD         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_en,
  input  logic [3:0] blank,
  input  logic       lzb,
  input  logic       freeze,
  output logic [3:0] anode,
  output logic [6:0] segment,
  output logic       dp
);

  localparam logic [REFRESH_WIDTH-1:0] RC_LAST  = REFRESH_WIDTH'(REFRESH_COUNT - 1);
  localparam logic [REFRESH_WIDTH-1:0] RC_GUARD = REFRESH_WIDTH'(GUARD);

  logic [REFRESH_WIDTH-1:0] rc;
  logic [1:0]               idx;
  logic                     init;
  logic [3:0]               s0, s1, s2, s3;
  logic [3:0]               s_dp, s_blank;

  logic       tick;
  logic       frame_start;
  logic       z1, z2, z3;
  logic [3:0] supp;
  logic [3:0] cur;
  logic       cur_supp;
  logic       cur_dark;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  always_comb begin
    tick        = (rc == RC_LAST);
    frame_start = (tick && (idx == 2'd3)) || init;
    z3          = (s3 == 4'd0);
    z2          = z3 && (s2 == 4'd0);
    z1          = z2 && (s1 == 4'd0);
    supp        = {z3, z2, z1, 1'b0} & {4{lzb}};
    case (idx)
      2'd0:    cur = s0;
      2'd1:    cur = s1;
      2'd2:    cur = s2;
      default: cur = s3;
    endcase
    cur_supp = supp[idx];
    // A suppressed digit keeps its anode on only to show a requested decimal point.
    cur_dark = s_blank[idx] || (cur_supp && !s_dp[idx]) || (rc < RC_GUARD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rc      <= '0;
      idx     <= 2'd0;
      init    <= 1'b1;
      s0      <= 4'd0;
      s1      <= 4'd0;
      s2      <= 4'd0;
      s3      <= 4'd0;
      s_dp    <= 4'd0;
      s_blank <= 4'd0;
      anode   <= 4'b1111;
      segment <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      init <= 1'b0;
      rc   <= tick ? '0 : rc + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      if (frame_start && !freeze) begin
        s0      <= digit0;
        s1      <= digit1;
        s2      <= digit2;
        s3      <= digit3;
        s_dp    <= dp_en;
        s_blank <= blank;
      end
      anode   <= cur_dark ? 4'b1111 : ~(4'b0001 << idx);
      segment <= (cur_dark || cur_supp) ? 7'b1111111 : decode(cur);
      dp      <= cur_dark ? 1'b1 : ~s_dp[idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised bench for seven_seg_scanner; expected outputs come from a cycle-count
// model of the scan schedule and frame captures, checked on the falling edge.
module tb_seven_seg_scanner;

  localparam int RC = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * RC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit0 = 4'd0, digit1 = 4'd0, digit2 = 4'd0, digit3 = 4'd0;
  logic [3:0] dp_en = 4'd0, blank = 4'd0;
  logic       lzb = 1'b0, freeze = 1'b0;
  logic [3:0] anode;
  logic [6:0] segment;
  logic       dp;

  int errors = 0;
  int checks = 0;

  seven_seg_scanner #(.REFRESH_COUNT(RC), .REFRESH_WIDTH(3), .GUARD(GD)) dut (
    .clk(clk), .reset(reset),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp_en(dp_en), .blank(blank), .lzb(lzb), .freeze(freeze),
    .anode(anode), .segment(segment), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: e_cnt = clock edges since reset release; shadows refreshed at frame starts.
  int         e_cnt = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_dp = 4'd0, m_blank = 4'd0;
  logic [3:0] exp_anode = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;
  logic       exp_dp = 1'b1;

  always @(posedge clk) begin
    int   pos, slot;
    logic sup, drk;
    logic [3:0] oh;
    if (!reset) begin
      e_cnt = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_dp = 4'd0;
      m_blank = 4'd0;
      exp_anode <= 4'b1111;
      exp_seg   <= 7'b1111111;
      exp_dp    <= 1'b1;
    end else begin
      pos  = e_cnt % RC;
      slot = (e_cnt / RC) % 4;
      sup  = 1'b0;
      if (lzb && slot != 0) begin
        sup = 1'b1;
        for (int j = slot; j < 4; j++) if (m_dig[j] != 4'd0) sup = 1'b0;
      end
      drk = m_blank[slot] || (sup && !m_dp[slot]) || (pos < GD);
      oh  = 4'b0001 << slot;
      exp_anode <= drk ? 4'b1111 : ~oh;
      exp_seg   <= (drk || sup) ? 7'b1111111 : seg_tab[m_dig[slot]];
      exp_dp    <= drk ? 1'b1 : ~m_dp[slot];
      if ((e_cnt == 0 || e_cnt % FRAME == FRAME - 1) && !freeze) begin
        m_dig[0] = digit0; m_dig[1] = digit1; m_dig[2] = digit2; m_dig[3] = digit3;
        m_dp = dp_en;
        m_blank = blank;
      end
      e_cnt++;
    end
  end

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  task automatic test_reset();
    set_digits(4, 3, 2, 1);
    lzb = 1'b0; dp_en = 4'd0; blank = 4'd0; freeze = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
        errors++;
        $display("FAIL reset: got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", anode, segment, dp);
      end
    end
  endtask

  task automatic test_first_frame();
    int lit;
    lit = 0;
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL first_frame c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
      if (i < RC + 1 && anode == 4'b1110) lit++;
      if (anode == 4'b1110) begin
        checks++;
        if (segment !== 7'b1111001) begin
          errors++;
          $display("FAIL first_frame_digit0: got seg=%b want 1111001", segment);
        end
      end
    end
    checks++;
    if (lit != RC - GD) begin
      errors++;
      $display("FAIL first_frame_slot0_len: got %0d lit cycles want %0d", lit, RC - GD);
    end
  endtask

  task automatic test_scan_order();
    int         s0, lowcnt;
    logic [3:0] seen, want;
    for (int w = 0; w < RC && (e_cnt % RC) != 0; w++) @(negedge clk);
    checks++;
    if ((e_cnt % RC) != 0) begin
      errors++;
      $display("FAIL scan_align: got pos=%0d want 0", e_cnt % RC);
    end
    s0 = (e_cnt / RC) % 4;
    for (int k = 0; k < 5; k++) begin
      lowcnt = 0;
      seen = 4'b1111;
      for (int c = 0; c < RC; c++) begin
        @(negedge clk);
        checks++;
        if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
          errors++;
          $display("FAIL scan c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   c, anode, segment, dp, exp_anode, exp_seg, exp_dp);
        end
        if (anode != 4'b1111) begin lowcnt++; seen = anode; end
      end
      want = ~(4'b0001 << ((s0 + k) % 4));
      checks++;
      if (seen !== want || lowcnt != RC - GD) begin
        errors++;
        $display("FAIL scan_slot%0d: got an=%b low=%0d want an=%b low=%0d", k, seen, lowcnt, want, RC - GD);
      end
    end
  endtask

  task automatic test_coherence();
    int w;
    set_digits(4, 3, 2, 1);
    for (w = 0; w < 2 * FRAME && !((e_cnt % FRAME) == RC + 3); w++) @(negedge clk);
    checks++;
    if ((e_cnt % FRAME) != RC + 3) begin
      errors++;
      $display("FAIL coherence_wait: got pos=%0d want %0d", e_cnt % FRAME, RC + 3);
    end
    set_digits(8, 7, 6, 5);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL coherence c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
      if (i < 3 * RC - 4 && anode == 4'b0111) begin
        checks++;
        if (segment !== seg_tab[4]) begin
          errors++;
          $display("FAIL coherence_old_d3: got seg=%b want %b", segment, seg_tab[4]);
        end
      end
    end
  endtask

  task automatic test_lzb();
    set_digits(0, 0, 0, 7);
    lzb = 1'b1; dp_en = 4'b0100;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL lzb c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
      if (i >= FRAME + 1) begin
        checks++;
        if (anode == 4'b0111 || anode == 4'b1101 ||
            (anode == 4'b1011 && {segment, dp} !== {7'b1111111, 1'b0}) ||
            (anode == 4'b1110 && segment !== 7'b1111000)) begin
          errors++;
          $display("FAIL lzb_pattern c%0d: got an=%b seg=%b dp=%b", i, anode, segment, dp);
        end
      end
    end
    set_digits(0, 0, 0, 0);
    dp_en = 4'd0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL lzb_zero c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
      if (i >= FRAME + 1 && anode == 4'b1110) begin
        checks++;
        if (segment !== 7'b1000000) begin
          errors++;
          $display("FAIL lzb_digit0_zero: got seg=%b want 1000000", segment);
        end
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_freeze();
    set_digits(4, 3, 2, 1);
    for (int i = 0; i < FRAME + 2; i++) @(negedge clk);
    freeze = 1'b1;
    @(negedge clk);
    set_digits(9, 9, 9, 9);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp} ||
          (anode == 4'b1110 && segment !== seg_tab[1])) begin
        errors++;
        $display("FAIL freeze_hold c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
    end
    freeze = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL freeze_release c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL random c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
      case ($urandom_range(0, 15))
        0: digit0 = 4'($urandom_range(0, 15));
        1: digit1 = 4'($urandom_range(0, 2));
        2: digit2 = 4'($urandom_range(0, 2));
        3: digit3 = 4'($urandom_range(0, 2));
        4: dp_en  = 4'($urandom_range(0, 15));
        5: blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        6: lzb    = 1'($urandom_range(0, 1));
        7: freeze = ($urandom_range(0, 3) == 0);
        default: ;
      endcase
    end
    freeze = 1'b0; blank = 4'd0; lzb = 1'b0; dp_en = 4'd0;
  endtask

  task automatic test_reset_mid();
    int w;
    set_digits(4, 3, 2, 1);
    for (w = 0; w < 2 * FRAME && (e_cnt % FRAME) != 2 * RC + 5; w++) @(negedge clk);
    checks++;
    if ((e_cnt % FRAME) != 2 * RC + 5) begin
      errors++;
      $display("FAIL reset_mid_wait: got pos=%0d want %0d", e_cnt % FRAME, 2 * RC + 5);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({anode, segment, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", anode, segment, dp);
    end
    @(negedge clk);
    reset = 1'b1;
    for (w = 0; w < 3 * RC && anode === 4'b1111; w++) @(negedge clk);
    checks++;
    if (anode !== 4'b1110 || segment !== seg_tab[1]) begin
      errors++;
      $display("FAIL reset_mid_restart: got an=%b seg=%b want an=1110 seg=%b", anode, segment, seg_tab[1]);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, segment, dp} !== {exp_anode, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL reset_mid_scan c%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, anode, segment, dp, exp_anode, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_scan_order();
    test_coherence();
    test_lzb();
    test_freeze();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
